// File: rtl/axis_packetizer.sv
// rtl/axis_packetizer.sv - frames a raw word stream into packets closed by length, upstream last or idle timeout
module axis_packetizer #(
  parameter  int DataWidth     = 32,
  parameter  int MaxPktLen     = 256,
  parameter  int TimeoutCycles = 64,
  localparam int CntWidth      = $clog2(MaxPktLen + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CntWidth-1:0]  pktLen,
  input  logic [DataWidth-1:0] inData,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic                 inLast,
  output logic [DataWidth-1:0] outData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 outLast,
  output logic [15:0]          pktCount,
  output logic                 timeoutEvent
);

  localparam int IdleWidth    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int TimeoutLimit = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
  localparam bit TimeoutEn    = (TimeoutCycles > 0);

  logic                 h_valid;
  logic                 h_last;
  logic [DataWidth-1:0] h_data;
  logic [CntWidth-1:0]  beat_cnt;
  logic [CntWidth-1:0]  len_lat;
  logic [CntWidth-1:0]  len_clamped;
  logic [CntWidth-1:0]  eff_len;
  logic [CntWidth-1:0]  beat_next;
  logic [IdleWidth-1:0] idle_cnt;
  logic                 out_free;
  logic                 accept;
  logic                 move;
  logic                 last_dec;
  logic                 idle_pending;
  logic                 timeout_hit;

  assign out_free = !outValid || outReady;
  // Gated by reset so every output reads 0 while reset is held.
  assign inReady  = reset && (!h_valid || out_free);
  assign accept   = inValid && inReady;
  assign move     = h_valid && out_free && (accept || h_last);

  assign len_clamped = (pktLen == '0 || pktLen > CntWidth'(MaxPktLen)) ? CntWidth'(MaxPktLen) : pktLen;
  assign eff_len     = (beat_cnt == '0) ? len_clamped : len_lat;
  assign beat_next   = beat_cnt + CntWidth'(1);
  assign last_dec    = inLast || (beat_next == eff_len);

  // An accept in the same cycle always beats the timeout.
  assign idle_pending = h_valid && !h_last && !accept;
  assign timeout_hit  = TimeoutEn && idle_pending && (idle_cnt == IdleWidth'(TimeoutLimit));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_valid <= 1'b0;
      h_last  <= 1'b0;
      h_data  <= '0;
    end else if (accept) begin
      h_valid <= 1'b1;
      h_data  <= inData;
      h_last  <= last_dec;
    end else if (move) begin
      h_valid <= 1'b0;
      h_last  <= 1'b0;
    end else if (timeout_hit) begin
      h_last  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
      len_lat  <= '0;
    end else if (accept) begin
      if (beat_cnt == '0) begin
        len_lat <= len_clamped;
      end
      beat_cnt <= last_dec ? '0 : beat_next;
    end else if (timeout_hit) begin
      beat_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt     <= '0;
      timeoutEvent <= 1'b0;
    end else begin
      timeoutEvent <= timeout_hit;
      if (TimeoutEn && idle_pending && !timeout_hit) begin
        idle_cnt <= idle_cnt + IdleWidth'(1);
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outValid <= 1'b0;
      outData  <= '0;
      outLast  <= 1'b0;
    end else if (move) begin
      outValid <= 1'b1;
      outData  <= h_data;
      outLast  <= h_last;
    end else if (outValid && outReady) begin
      outValid <= 1'b0;
      outLast  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pktCount <= '0;
    end else if (outValid && outReady && outLast) begin
      pktCount <= pktCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_packetizer.sv
// tb/tb_axis_packetizer.sv - directed bench for axis_packetizer: cycle vector table plus multi-cycle sequences
module tb_axis_packetizer;

  localparam int DW = 32;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] pktLen;
  logic [DW-1:0] inData;
  logic          inValid;
  logic          inReady;
  logic          inLast;
  logic [DW-1:0] outData;
  logic          outValid;
  logic          outReady;
  logic          outLast;
  logic [15:0]   pktCount;
  logic          timeoutEvent;

  int checks = 0;
  int errors = 0;
  int tmo_cnt = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        il;
    logic [8:0]  len;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_ol;
    logic [15:0] e_pc;
  } vec_t;

  beat_t out_q[$];
  beat_t exp_q[$];
  vec_t  vecs[11];

  always #5 clk = ~clk;

  axis_packetizer #(
    .DataWidth(32),
    .MaxPktLen(256),
    .TimeoutCycles(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pktLen(pktLen),
    .inData(inData),
    .inValid(inValid),
    .inReady(inReady),
    .inLast(inLast),
    .outData(outData),
    .outValid(outValid),
    .outReady(outReady),
    .outLast(outLast),
    .pktCount(pktCount),
    .timeoutEvent(timeoutEvent)
  );

  always @(negedge clk) begin
    beat_t b;
    if (outValid && outReady) begin
      b.data = outData;
      b.last = outLast;
      out_q.push_back(b);
    end
    if (timeoutEvent) tmo_cnt <= tmo_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    inValid = 1'b1;
    inData  = d;
    inLast  = l;
    #1;
    while (!inReady && n < 200) begin
      tick();
      n++;
    end
    check("send ready", inReady, 1);
    tick();
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic check_stream(input string name, input int budget);
    int n = 0;
    while (out_q.size() < exp_q.size() && n < budget) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check({name, " count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < out_q.size()) begin
        check($sformatf("%s data[%0d]", name, i), out_q[i].data, exp_q[i].data);
        check($sformatf("%s last[%0d]", name, i), out_q[i].last, exp_q[i].last);
      end
    end
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, " outValid"}, outValid, 0);
    check({name, " outData"}, outData, 0);
    check({name, " outLast"}, outLast, 0);
    check({name, " pktCount"}, pktCount, 0);
    check({name, " timeoutEvent"}, timeoutEvent, 0);
    check({name, " inReady"}, inReady, 0);
  endtask

  initial begin
    int tmo_base;
    int acc;

    //           iv    id          il    len    ordy | ir    ov    od          ol    pc
    vecs[0]  = '{1'b1, 32'h000000A0, 1'b0, 9'd2, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0};
    vecs[1]  = '{1'b1, 32'h000000A1, 1'b0, 9'd2, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0};
    vecs[2]  = '{1'b0, 32'h00000000, 1'b0, 9'd2, 1'b0, 1'b0, 1'b1, 32'h000000A0, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 32'h000000B0, 1'b0, 9'd2, 1'b0, 1'b0, 1'b1, 32'h000000A0, 1'b0, 16'd0};
    vecs[4]  = '{1'b1, 32'h000000B0, 1'b0, 9'd2, 1'b1, 1'b1, 1'b1, 32'h000000A0, 1'b0, 16'd0};
    vecs[5]  = '{1'b1, 32'h000000B1, 1'b0, 9'd2, 1'b1, 1'b1, 1'b1, 32'h000000A1, 1'b1, 16'd0};
    vecs[6]  = '{1'b0, 32'h00000000, 1'b0, 9'd2, 1'b1, 1'b1, 1'b1, 32'h000000B0, 1'b0, 16'd1};
    vecs[7]  = '{1'b1, 32'h000000C0, 1'b1, 9'd2, 1'b1, 1'b1, 1'b1, 32'h000000B1, 1'b1, 16'd1};
    vecs[8]  = '{1'b0, 32'h00000000, 1'b0, 9'd2, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd2};
    vecs[9]  = '{1'b0, 32'h00000000, 1'b0, 9'd2, 1'b1, 1'b1, 1'b1, 32'h000000C0, 1'b1, 16'd2};
    vecs[10] = '{1'b0, 32'h00000000, 1'b0, 9'd2, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd3};

    reset    = 1'b0;
    pktLen   = '0;
    inData   = '0;
    inValid  = 1'b0;
    inLast   = 1'b0;
    outReady = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      inValid  = vecs[i].iv;
      inData   = vecs[i].id;
      inLast   = vecs[i].il;
      pktLen   = vecs[i].len;
      outReady = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d inReady", i), inReady, vecs[i].e_ir);
      check($sformatf("vec%0d outValid", i), outValid, vecs[i].e_ov);
      if (vecs[i].e_ov) begin
        check($sformatf("vec%0d outData", i), outData, vecs[i].e_od);
        check($sformatf("vec%0d outLast", i), outLast, vecs[i].e_ol);
      end
      check($sformatf("vec%0d pktCount", i), pktCount, vecs[i].e_pc);
      tick();
    end
    inValid = 1'b0;
    inLast  = 1'b0;
    out_q.delete();

    // length framing
    pktLen   = 9'd4;
    outReady = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(i, 1'b0);
      expect_beat(i, (i % 4) == 3);
    end
    check_stream("framing", 50);
    check("framing pktCount", pktCount, 6);

    // upstream last, then the count restarts
    pktLen = 9'd8;
    send(20, 1'b0);
    send(21, 1'b0);
    send(22, 1'b1);
    expect_beat(20, 1'b0);
    expect_beat(21, 1'b0);
    expect_beat(22, 1'b1);
    for (int i = 23; i <= 30; i++) begin
      send(i, 1'b0);
      expect_beat(i, i == 30);
    end
    check_stream("upstream", 50);
    check("upstream pktCount", pktCount, 8);

    // idle timeout
    pktLen   = 9'd16;
    tmo_base = tmo_cnt;
    for (int i = 100; i <= 104; i++) begin
      send(i, 1'b0);
      expect_beat(i, i == 104);
    end
    for (int k = 1; k <= 66; k++) begin
      tick();
      if (k == 63 || k == 65) check($sformatf("timeout pulse k%0d", k), timeoutEvent, 0);
      if (k == 64) check("timeout pulse k64", timeoutEvent, 1);
    end
    check_stream("timeout", 20);
    check("timeout events", tmo_cnt - tmo_base, 1);
    check("timeout pktCount", pktCount, 9);

    // backpressure with both registers full
    pktLen   = 9'd3;
    outReady = 1'b0;
    acc      = 0;
    for (int c = 0; c < 20; c++) begin
      inValid = 1'b1;
      inData  = 200 + acc;
      inLast  = 1'b0;
      #1;
      check($sformatf("bp inReady c%0d", c), inReady, c < 2);
      if (c >= 2) begin
        check($sformatf("bp outValid c%0d", c), outValid, 1);
        check($sformatf("bp outData c%0d", c), outData, 200);
      end
      if (inReady) acc++;
      tick();
    end
    check("bp accepted", acc, 2);
    outReady = 1'b1;
    for (int i = acc; i < 9; i++) send(200 + i, 1'b0);
    for (int i = 0; i < 9; i++) expect_beat(200 + i, (i % 3) == 2);
    check_stream("backpressure", 50);
    check("bp pktCount", pktCount, 12);

    // clamp: zero and oversize lengths both frame at 256
    pktLen = 9'd0;
    for (int i = 0; i < 256; i++) begin
      send(1000 + i, 1'b0);
      expect_beat(1000 + i, i == 255);
    end
    check_stream("clamp0", 20);
    pktLen = 9'd300;
    for (int i = 0; i < 256; i++) begin
      send(2000 + i, 1'b0);
      expect_beat(2000 + i, i == 255);
    end
    check_stream("clamp300", 20);
    check("clamp pktCount", pktCount, 14);

    pktLen = 9'd1;
    for (int i = 0; i < 3; i++) begin
      send(3000 + i, 1'b0);
      expect_beat(3000 + i, 1'b1);
    end
    check_stream("len1", 20);
    check("len1 pktCount", pktCount, 17);

    // accept lands on the very edge the timeout would fire
    pktLen   = 9'd16;
    tmo_base = tmo_cnt;
    send(4000, 1'b0);
    repeat (63) tick();
    inValid = 1'b1;
    inData  = 4001;
    inLast  = 1'b0;
    #1;
    check("coinc inReady", inReady, 1);
    tick();
    inValid = 1'b0;
    check("coinc timeoutEvent", timeoutEvent, 0);
    send(4002, 1'b1);
    expect_beat(4000, 1'b0);
    expect_beat(4001, 1'b0);
    expect_beat(4002, 1'b1);
    check_stream("coinc", 20);
    check("coinc events", tmo_cnt - tmo_base, 0);
    check("coinc pktCount", pktCount, 18);

    // reset mid-packet
    pktLen = 9'd8;
    send(300, 1'b0);
    send(301, 1'b0);
    send(302, 1'b0);
    expect_beat(300, 1'b0);
    expect_beat(301, 1'b0);
    check_stream("prereset", 10);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("postreset pktCount", pktCount, 0);
    tmo_base = tmo_cnt;
    pktLen   = 9'd3;
    for (int i = 0; i < 3; i++) begin
      send(400 + i, 1'b0);
      expect_beat(400 + i, i == 2);
    end
    check_stream("postreset", 10);
    check("postreset pktCount1", pktCount, 1);
    check("postreset events", tmo_cnt - tmo_base, 0);
    check("total timeouts", tmo_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
